// File: rtl/mcpu_ctrl_pkg.sv
// Shared definitions for the multi-cycle MIPS controller: state codes,
// opcode/funct constants, ALU operation codes and the ID-stage decode.
// Optional feature macro: MCPU_CTRL_JAL_EN (enables the JAL state).
package mcpu_ctrl_pkg;

    typedef enum logic [3:0] {
        ST_IF      = 4'd0,
        ST_ID      = 4'd1,
        ST_MEM_ADR = 4'd2,
        ST_MEM_RD  = 4'd3,
        ST_MEM_WB  = 4'd4,
        ST_MEM_WR  = 4'd5,
        ST_R_EX    = 4'd6,
        ST_R_WB    = 4'd7,
        ST_I_EX    = 4'd8,
        ST_I_WB    = 4'd9,
        ST_BEQ     = 4'd10,
        ST_BNE     = 4'd11,
        ST_J       = 4'd12,
        ST_JAL     = 4'd13
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_XOR = 6'b100110;
    localparam logic [5:0] FN_NOR = 6'b100111;
    localparam logic [5:0] FN_SLT = 6'b101010;
    localparam logic [5:0] FN_SRL = 6'b000010;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_XOR = 3'b011;
    localparam logic [2:0] ALU_NOR = 3'b100;
    localparam logic [2:0] ALU_SRL = 3'b101;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    // True for the R-type functions the datapath implements.
    function automatic logic is_r_funct(input logic [5:0] funct);
        return funct inside {FN_ADD, FN_SUB, FN_AND, FN_OR, FN_XOR,
                             FN_NOR, FN_SLT, FN_SRL};
    endfunction

    // State following ID; anything unsupported drops back to fetch.
    function automatic state_t decode_id(input logic [5:0] op, input logic [5:0] funct);
        state_t nxt;
        nxt = ST_IF;
        case (op)
            OP_RTYPE:      if (is_r_funct(funct)) nxt = ST_R_EX;
            OP_LW, OP_SW:  nxt = ST_MEM_ADR;
            OP_BEQ:        nxt = ST_BEQ;
            OP_BNE:        nxt = ST_BNE;
            OP_J:          nxt = ST_J;
`ifdef MCPU_CTRL_JAL_EN
            OP_JAL:        nxt = ST_JAL;
`endif
            OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI, OP_XORI: nxt = ST_I_EX;
            default:       nxt = ST_IF;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/mcpu_ctrl_alu_dec.sv
// ALU operation decoder: fetch/decode/address states add, branches
// subtract, execute states follow funct (R-type) or opcode (I-type).
module mcpu_alu_dec
    import mcpu_ctrl_pkg::*;
(
    input  state_t      state,
    input  logic [5:0]  op,
    input  logic [5:0]  funct,
    output logic [2:0]  alu_op
);

    // Combinational map from (state, op, funct) to the ALU code.
    always_comb begin
        alu_op = ALU_AND;
        case (state)
            ST_IF, ST_ID, ST_MEM_ADR: alu_op = ALU_ADD;
            ST_R_EX: begin
                case (funct)
                    FN_ADD:  alu_op = ALU_ADD;
                    FN_SUB:  alu_op = ALU_SUB;
                    FN_AND:  alu_op = ALU_AND;
                    FN_OR:   alu_op = ALU_OR;
                    FN_XOR:  alu_op = ALU_XOR;
                    FN_NOR:  alu_op = ALU_NOR;
                    FN_SLT:  alu_op = ALU_SLT;
                    FN_SRL:  alu_op = ALU_SRL;
                    default: alu_op = ALU_ADD;
                endcase
            end
            ST_I_EX: begin
                case (op)
                    OP_ADDI: alu_op = ALU_ADD;
                    OP_SLTI: alu_op = ALU_SLT;
                    OP_ANDI: alu_op = ALU_AND;
                    OP_ORI:  alu_op = ALU_OR;
                    OP_XORI: alu_op = ALU_XOR;
                    default: alu_op = ALU_ADD;
                endcase
            end
            ST_BEQ, ST_BNE: alu_op = ALU_SUB;
            default: alu_op = ALU_AND;
        endcase
    end

endmodule

// File: rtl/mcpu_ctrl.sv
// Multi-cycle MIPS control unit: Moore FSM with memory-ready handshakes
// in fetch and memory access. Write enables are held low during reset.
// Optional feature macro: MCPU_CTRL_JAL_EN (jump-and-link support).
module mcpu_ctrl
    import mcpu_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Inst,
    input  logic        zero,
    input  logic        MIO_ready,
    output logic        IRWrite,
    output logic [1:0]  RegDst,
    output logic [1:0]  MemtoReg,
    output logic        RegWrite,
    output logic        ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic [2:0]  ALU_operation,
    output logic        IorD,
    output logic [1:0]  PCSource,
    output logic        Branch,
    output logic        PCWriteCond,
    output logic        PCWrite,
    output logic        MemRead,
    output logic        MemWrite,
    output logic [3:0]  state_out
);

    state_t     state_q, state_d;
    logic [5:0] op, funct;

    assign op        = Inst[31:26];
    assign funct     = Inst[5:0];
    assign state_out = state_q;

    // Branch resolution lives in the datapath, so zero is not consulted here.
    logic unused_inputs;
    assign unused_inputs = ^{zero, Inst[25:6]};

    // State register; reset forces fetch immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= ST_IF;
        else       state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IF:      if (MIO_ready) state_d = ST_ID;
            ST_ID:      state_d = decode_id(op, funct);
            ST_MEM_ADR: state_d = (op == OP_SW) ? ST_MEM_WR : ST_MEM_RD;
            ST_MEM_RD:  if (MIO_ready) state_d = ST_MEM_WB;
            ST_MEM_WR:  if (MIO_ready) state_d = ST_IF;
            ST_R_EX:    state_d = ST_R_WB;
            ST_I_EX:    state_d = ST_I_WB;
            default:    state_d = ST_IF;
        endcase
    end

    mcpu_alu_dec u_alu_dec (
        .state  (state_q),
        .op     (op),
        .funct  (funct),
        .alu_op (ALU_operation)
    );

    // Per-state output decode; reset suppresses every write enable.
    always_comb begin
        IRWrite     = 1'b0;
        RegDst      = 2'b00;
        MemtoReg    = 2'b00;
        RegWrite    = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = 2'b00;
        IorD        = 1'b0;
        PCSource    = 2'b00;
        Branch      = 1'b0;
        PCWriteCond = 1'b0;
        PCWrite     = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        case (state_q)
            ST_IF: begin
                MemRead = 1'b1;
                ALUSrcB = 2'b01;
                IRWrite = MIO_ready;
                PCWrite = MIO_ready;
            end
            ST_ID:      ALUSrcB = 2'b11;
            ST_MEM_ADR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
            end
            ST_MEM_RD: begin
                IorD    = 1'b1;
                MemRead = 1'b1;
            end
            ST_MEM_WB: begin
                MemtoReg = 2'b01;
                RegWrite = 1'b1;
            end
            ST_MEM_WR: begin
                IorD     = 1'b1;
                MemWrite = 1'b1;
            end
            ST_R_EX:    ALUSrcA = 1'b1;
            ST_R_WB: begin
                RegDst   = 2'b01;
                RegWrite = 1'b1;
            end
            ST_I_EX: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
            end
            ST_I_WB:    RegWrite = 1'b1;
            ST_BEQ, ST_BNE: begin
                ALUSrcA     = 1'b1;
                PCWriteCond = 1'b1;
                PCSource    = 2'b01;
                Branch      = (state_q == ST_BEQ);
            end
            ST_J: begin
                PCSource = 2'b10;
                PCWrite  = 1'b1;
            end
`ifdef MCPU_CTRL_JAL_EN
            ST_JAL: begin
                PCSource = 2'b10;
                PCWrite  = 1'b1;
                RegWrite = 1'b1;
                RegDst   = 2'b10;
                MemtoReg = 2'b10;
            end
`endif
            default: ;
        endcase
        if (reset) begin
            IRWrite     = 1'b0;
            PCWrite     = 1'b0;
            PCWriteCond = 1'b0;
            RegWrite    = 1'b0;
            MemWrite    = 1'b0;
        end
    end

endmodule
